// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a decoded op, register indices and an immediate into a word.
// Streams words tagged with instruction-memory addresses, substituting a NOP for unencodable requests.
package opcodes_pkg;
    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ECALL, OP_EBREAK, OP_INVALID
    } opcode_out_t;
endpackage

module instr_encoder
    import opcodes_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  opcode_out_t       opcode_in,
    input  logic [4:0]        rd_in,
    input  logic [4:0]        rs1_in,
    input  logic [4:0]        rs2_in,
    input  logic [31:0]       imm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_out,
    output logic              err_flag
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_BAD
    } fmt_t;

    fmt_t        fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  major;
    logic        isEbreak;
    logic [31:0] encWord;
    logic        encErr;
    logic        immIOk, immShOk, immBOk, immUOk, immJOk;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              errOut_q, errOut_d;
    logic              errFlag_q, errFlag_d;

    logic accept;
    logic outFire;

    // Representability: the upper bits must be a pure sign extension of the encodable field.
    assign immIOk  = (&imm_in[31:11]) | ~(|imm_in[31:11]);
    assign immShOk = ~(|imm_in[31:5]);
    assign immBOk  = ((&imm_in[31:12]) | ~(|imm_in[31:12])) & ~imm_in[0];
    assign immUOk  = ~(|imm_in[11:0]);
    assign immJOk  = ((&imm_in[31:20]) | ~(|imm_in[31:20])) & ~imm_in[0];

    always_comb begin
        fmt      = FMT_BAD;
        f3       = 3'b000;
        f7       = 7'b0000000;
        major    = 7'b0010011;
        isEbreak = 1'b0;
        case (opcode_in)
            OP_ADD:    fmt = FMT_R;
            OP_SUB:    begin fmt = FMT_R; f7 = 7'b0100000; end
            OP_SLL:    begin fmt = FMT_R; f3 = 3'b001; end
            OP_SLT:    begin fmt = FMT_R; f3 = 3'b010; end
            OP_SLTU:   begin fmt = FMT_R; f3 = 3'b011; end
            OP_XOR:    begin fmt = FMT_R; f3 = 3'b100; end
            OP_SRL:    begin fmt = FMT_R; f3 = 3'b101; end
            OP_SRA:    begin fmt = FMT_R; f3 = 3'b101; f7 = 7'b0100000; end
            OP_OR:     begin fmt = FMT_R; f3 = 3'b110; end
            OP_AND:    begin fmt = FMT_R; f3 = 3'b111; end
            OP_ADDI:   fmt = FMT_I;
            OP_SLTI:   begin fmt = FMT_I; f3 = 3'b010; end
            OP_SLTIU:  begin fmt = FMT_I; f3 = 3'b011; end
            OP_XORI:   begin fmt = FMT_I; f3 = 3'b100; end
            OP_ORI:    begin fmt = FMT_I; f3 = 3'b110; end
            OP_ANDI:   begin fmt = FMT_I; f3 = 3'b111; end
            OP_SLLI:   begin fmt = FMT_SH; f3 = 3'b001; end
            OP_SRLI:   begin fmt = FMT_SH; f3 = 3'b101; end
            OP_SRAI:   begin fmt = FMT_SH; f3 = 3'b101; f7 = 7'b0100000; end
            OP_LB:     begin fmt = FMT_I; major = 7'b0000011; end
            OP_LH:     begin fmt = FMT_I; major = 7'b0000011; f3 = 3'b001; end
            OP_LW:     begin fmt = FMT_I; major = 7'b0000011; f3 = 3'b010; end
            OP_LBU:    begin fmt = FMT_I; major = 7'b0000011; f3 = 3'b100; end
            OP_LHU:    begin fmt = FMT_I; major = 7'b0000011; f3 = 3'b101; end
            OP_SB:     fmt = FMT_S;
            OP_SH:     begin fmt = FMT_S; f3 = 3'b001; end
            OP_SW:     begin fmt = FMT_S; f3 = 3'b010; end
            OP_BEQ:    fmt = FMT_B;
            OP_BNE:    begin fmt = FMT_B; f3 = 3'b001; end
            OP_BLT:    begin fmt = FMT_B; f3 = 3'b100; end
            OP_BGE:    begin fmt = FMT_B; f3 = 3'b101; end
            OP_BLTU:   begin fmt = FMT_B; f3 = 3'b110; end
            OP_BGEU:   begin fmt = FMT_B; f3 = 3'b111; end
            OP_LUI:    begin fmt = FMT_U; major = 7'b0110111; end
            OP_AUIPC:  begin fmt = FMT_U; major = 7'b0010111; end
            OP_JAL:    fmt = FMT_J;
            OP_JALR:   begin fmt = FMT_I; major = 7'b1100111; end
            OP_ECALL:  fmt = FMT_SYS;
            OP_EBREAK: begin fmt = FMT_SYS; isEbreak = 1'b1; end
            default:   fmt = FMT_BAD;
        endcase
    end

    // Any branch that does not set encErr low leaves the NOP substitution in place.
    always_comb begin
        encWord = NOP;
        encErr  = 1'b1;
        case (fmt)
            FMT_R: begin
                encWord = {f7, rs2_in, rs1_in, f3, rd_in, 7'b0110011};
                encErr  = 1'b0;
            end
            FMT_I: if (immIOk) begin
                encWord = {imm_in[11:0], rs1_in, f3, rd_in, major};
                encErr  = 1'b0;
            end
            FMT_SH: if (immShOk) begin
                encWord = {f7, imm_in[4:0], rs1_in, f3, rd_in, 7'b0010011};
                encErr  = 1'b0;
            end
            FMT_S: if (immIOk) begin
                encWord = {imm_in[11:5], rs2_in, rs1_in, f3, imm_in[4:0], 7'b0100011};
                encErr  = 1'b0;
            end
            FMT_B: if (immBOk) begin
                encWord = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, f3,
                           imm_in[4:1], imm_in[11], 7'b1100011};
                encErr  = 1'b0;
            end
            FMT_U: if (immUOk) begin
                encWord = {imm_in[31:12], rd_in, major};
                encErr  = 1'b0;
            end
            FMT_J: if (immJOk) begin
                encWord = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, 7'b1101111};
                encErr  = 1'b0;
            end
            FMT_SYS: begin
                encWord = {11'b0, isEbreak, 13'b0, 7'b1110011};
                encErr  = 1'b0;
            end
            default: begin
                encWord = NOP;
                encErr  = 1'b1;
            end
        endcase
    end

    assign in_ready = rst_n & ~clear_in & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign outFire  = valid_q & out_ready;

    // out_addr names the word currently held, so it steps only when that word leaves.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        errOut_d  = errOut_q;
        errFlag_d = errFlag_q;
        if (outFire) begin
            addr_d  = addr_q + ADDR_W'(4);
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d   = 1'b1;
            instr_d   = encWord;
            errOut_d  = encErr;
            errFlag_d = errFlag_q | encErr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_in) begin
            valid_q   <= 1'b0;
            instr_q   <= 32'h0;
            addr_q    <= BASE_ADDR;
            errOut_q  <= 1'b0;
            errFlag_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            errOut_q  <= errOut_d;
            errFlag_q <= errFlag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err_out   = errOut_q;
    assign err_flag  = errFlag_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, immediate range limits, stall, clear/reset.
// A second instance with a 4-bit address starting at 0xC tracks address wrap alongside the main one.
module tb_instr_encoder;
    import opcodes_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, clear_in, in_valid, out_ready;
    opcode_out_t opcode_in;
    logic [4:0]  rd_in, rs1_in, rs2_in;
    logic [31:0] imm_in;

    logic        in_ready, out_valid, err_out, err_flag;
    logic [31:0] out_instr, out_addr;
    logic        in_ready2, out_valid2, err_out2, err_flag2;
    logic [31:0] out_instr2;
    logic [3:0]  out_addr2;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expAddr;
    logic [3:0]  expAddr2;
    logic        expFlag;

    typedef struct {
        opcode_out_t op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_out(err_out), .err_flag(err_flag)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dutWrap (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode_in(opcode_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2),
        .err_out(err_out2), .err_flag(err_flag2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic addVec(input opcode_out_t op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] word,
                          input logic err);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.word = word; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic driveInputs(input vec_t v);
        opcode_in = v.op;
        rd_in     = v.rd;
        rs1_in    = v.rs1;
        rs2_in    = v.rs2;
        imm_in    = v.imm;
        in_valid  = 1'b1;
    endtask

    // Present one request and return #1 after the edge that accepted it.
    task automatic applyStimulus(input vec_t v);
        int waitCycles;
        @(negedge clk);
        driveInputs(v);
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Each word is consumed on the following edge because out_ready is high, so the address model steps here.
    task automatic checkWord(input string name, input vec_t v);
        if (v.err) expFlag = 1'b1;
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_instr"}, out_instr, v.word);
        checkOutput({name, "_err"}, 32'(err_out), 32'(v.err));
        checkOutput({name, "_addr"}, out_addr, expAddr);
        checkOutput({name, "_flag"}, 32'(err_flag), 32'(expFlag));
        checkOutput({name, "_addr4"}, 32'(out_addr2), 32'(expAddr2));
        expAddr  = expAddr + 32'd4;
        expAddr2 = expAddr2 + 4'd4;
    endtask

    initial begin
        vec_t stallVec;
        vec_t addVecA;
        logic [31:0] stallAddr;

        addVec(OP_ADDI,   5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0);
        addVec(OP_SW,     5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0);
        addVec(OP_JAL,    5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF, 1'b0);
        addVec(OP_LUI,    5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b0);
        addVec(OP_ADD,    5'd3, 5'd1, 5'd2, 32'hFFFFFFFF,   32'h002081B3, 1'b0);
        addVec(OP_SUB,    5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0);
        addVec(OP_SRAI,   5'd1, 5'd2, 5'd0, 32'd3,          32'h40315093, 1'b0);
        addVec(OP_BEQ,    5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0);
        addVec(OP_ADDI,   5'd1, 5'd0, 5'd0, 32'hFFFFF800,   32'h80000093, 1'b0);
        addVec(OP_BEQ,    5'd0, 5'd0, 5'd0, 32'd4094,       32'h7E000FE3, 1'b0);
        addVec(OP_ECALL,  5'd0, 5'd0, 5'd0, 32'd0,          32'h00000073, 1'b0);
        addVec(OP_ADDI,   5'd1, 5'd0, 5'd0, 32'd2048,       32'h00000013, 1'b1);
        addVec(OP_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0,          32'h00100073, 1'b0);
        addVec(OP_BEQ,    5'd0, 5'd1, 5'd2, 32'd3,          32'h00000013, 1'b1);
        addVec(OP_LUI,    5'd5, 5'd0, 5'd0, 32'h00001001,   32'h00000013, 1'b1);
        addVec(OP_BEQ,    5'd0, 5'd0, 5'd0, 32'd4096,       32'h00000013, 1'b1);
        addVec(OP_SLLI,   5'd1, 5'd1, 5'd0, 32'd32,         32'h00000013, 1'b1);
        addVec(OP_INVALID,5'd1, 5'd1, 5'd1, 32'd0,          32'h00000013, 1'b1);

        rst_n = 1'b0; clear_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode_in = OP_ADDI; rd_in = '0; rs1_in = '0; rs2_in = '0; imm_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_instr", out_instr, 32'h0);
        checkOutput("rst_addr", out_addr, 32'h0);
        checkOutput("rst_err", 32'(err_out), 32'd0);
        checkOutput("rst_flag", 32'(err_flag), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_addr4", 32'(out_addr2), 32'hC);
        @(negedge clk);
        rst_n    = 1'b1;
        expAddr  = 32'h0;
        expAddr2 = 4'hC;
        expFlag  = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkWord($sformatf("v%0d", i), vecs[i]);
        end

        // Backpressure: hold the ADDI word for three edges while an ADD request waits.
        stallVec = vecs[0];
        addVecA  = vecs[4];
        applyStimulus(stallVec);
        stallAddr = expAddr;
        checkWord("stall_first", stallVec);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) driveInputs(addVecA);
            checkOutput($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall%0d_instr", k), out_instr, 32'h00500093);
            checkOutput($sformatf("stall%0d_addr", k), out_addr, stallAddr);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkWord("stall_release", addVecA);

        // Clear with a word pending and err_flag set.
        applyStimulus(vecs[1]);
        checkWord("pre_clear", vecs[1]);
        out_ready = 1'b0;
        clear_in  = 1'b1;
        #1;
        checkOutput("clear_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear_in = 1'b0;
        checkOutput("clear_valid", 32'(out_valid), 32'd0);
        checkOutput("clear_addr", out_addr, 32'h0);
        checkOutput("clear_flag", 32'(err_flag), 32'd0);
        checkOutput("clear_addr4", 32'(out_addr2), 32'hC);
        expAddr   = 32'h0;
        expAddr2  = 4'hC;
        expFlag   = 1'b0;
        out_ready = 1'b1;

        applyStimulus(vecs[2]);
        checkWord("wrap0", vecs[2]);
        applyStimulus(vecs[3]);
        checkWord("wrap1", vecs[3]);

        // Reset mid-stream after an error word.
        applyStimulus(vecs[11]);
        checkWord("pre_reset", vecs[11]);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("mrst_valid", 32'(out_valid), 32'd0);
        checkOutput("mrst_instr", out_instr, 32'h0);
        checkOutput("mrst_addr", out_addr, 32'h0);
        checkOutput("mrst_flag", 32'(err_flag), 32'd0);
        expAddr   = 32'h0;
        expAddr2  = 4'hC;
        expFlag   = 1'b0;
        out_ready = 1'b1;
        applyStimulus(vecs[0]);
        checkWord("post_reset", vecs[0]);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
